// File: rtl/booth_mul_pkg.sv
// Shared widths and tracking-pipe entry type for the Booth multiplier arbiter.
package booth_mul_pkg;

  localparam int N_REQ = 4;
  localparam int WA    = 11;
  localparam int WB    = 10;
  localparam int WP    = 21;
  localparam int TAG_W = $clog2(N_REQ);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } trk_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest eligible index at or after ptr, else lowest eligible overall.
module rr_arbiter #(
  parameter int N_REQ = booth_mul_pkg::N_REQ
) (
  input  logic [N_REQ-1:0]         eligible,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant
);

  localparam int TW = $clog2(N_REQ);

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] hi;
  logic [N_REQ-1:0] pick;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hi_mask[i] = (TW'(i) >= ptr);
    end
    hi    = eligible & hi_mask;
    pick  = (|hi) ? hi : eligible;
    // isolate lowest set bit
    grant = pick & (~pick + 1'b1);
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one external Booth multiplier among N_REQ requesters: round-robin issue,
// tag tracking through LAT multiplier stages, and a product buffer per requester.
module booth_mul_arbiter #(
  parameter int N_REQ = booth_mul_pkg::N_REQ,
  parameter int WA    = booth_mul_pkg::WA,
  parameter int WB    = booth_mul_pkg::WB,
  parameter int WP    = booth_mul_pkg::WP,
  parameter int LAT   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*WA-1:0] req_a,
  input  logic [N_REQ*WB-1:0] req_b,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [N_REQ*WP-1:0] rsp_p,
  output logic [WA-1:0]       mul_a,
  output logic [WB-1:0]       mul_b,
  input  logic [WP-1:0]       mul_p,
  output logic                idle
);

  localparam int TW = $clog2(N_REQ);

  typedef struct packed {
    logic          valid;
    logic [TW-1:0] tag;
  } trk_t;

  trk_t [LAT:0]     pipe;
  trk_t             last;
  logic [TW-1:0]    ptr;
  logic [TW-1:0]    ptr_nxt;
  logic [TW-1:0]    gnt_idx;
  logic [WA-1:0]    sel_a;
  logic [WB-1:0]    sel_b;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] inflight;
  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] eligible;

  assign last = pipe[LAT];

  always_comb begin
    inflight = '0;
    for (int s = 0; s <= LAT; s++) begin
      if (pipe[s].valid) inflight[pipe[s].tag] = 1'b1;
    end
  end

  assign busy      = inflight | rsp_valid;
  assign eligible  = req_valid & ~busy;
  assign req_ready = grant;
  assign idle      = ~|busy;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant)
  );

  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = TW'(i);
        sel_a   = req_a[i*WA +: WA];
        sel_b   = req_b[i*WB +: WB];
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (|grant) ptr_nxt = (gnt_idx == TW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      pipe  <= '0;
    end else begin
      ptr     <= ptr_nxt;
      pipe[0] <= {|grant, gnt_idx};
      for (int s = 1; s <= LAT; s++) begin
        pipe[s] <= pipe[s-1];
      end
      if (|grant) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
    end
  end

  // busy keeps a capture and a drain of the same slot from ever coinciding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_p     <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) rsp_valid[i] <= 1'b0;
        if (last.valid && (last.tag == TW'(i))) begin
          rsp_valid[i]        <= 1'b1;
          rsp_p[i*WP +: WP]   <= mul_p;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: LAT=0 and LAT=2 instances share stimulus, each with its own reference model.
module tb_booth_mul_arbiter;
  import booth_mul_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [N_REQ*WA-1:0] req_a;
  logic [N_REQ*WB-1:0] req_b;

  logic [N_REQ-1:0]    rdy [2];
  logic [N_REQ-1:0]    vld [2];
  logic [N_REQ*WP-1:0] rp  [2];
  logic [WA-1:0]       ma  [2];
  logic [WB-1:0]       mb  [2];
  logic [WP-1:0]       mp  [2];
  logic                idl [2];
  logic [WP-1:0]       d1, d2;

  int cyc   = 0;
  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WP-1:0] prod(input logic [WA-1:0] a, input logic [WB-1:0] b);
    logic signed [WP-1:0] sa, sb;
    sa = {{(WP-WA){a[WA-1]}}, a};
    sb = {{(WP-WB){b[WB-1]}}, b};
    return sa * sb;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [WA-1:0] a, input logic [WB-1:0] b);
    req_a[i*WA +: WA] = a;
    req_b[i*WB +: WB] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N_REQ; i++) set_op(i, WA'($urandom), WB'($urandom));
  endtask

  booth_mul_arbiter #(.LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_a(req_a), .req_b(req_b), .rsp_valid(vld[0]), .rsp_ready(rsp_ready),
    .rsp_p(rp[0]), .mul_a(ma[0]), .mul_b(mb[0]), .mul_p(mp[0]), .idle(idl[0])
  );

  booth_mul_arbiter #(.LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_a(req_a), .req_b(req_b), .rsp_valid(vld[1]), .rsp_ready(rsp_ready),
    .rsp_p(rp[1]), .mul_a(ma[1]), .mul_b(mb[1]), .mul_p(mp[1]), .idle(idl[1])
  );

  // external multipliers: combinational, and two register stages
  assign mp[0] = prod(ma[0], mb[0]);
  always @(posedge clk) begin
    d1 <= prod(ma[1], mb[1]);
    d2 <= d1;
  end
  assign mp[1] = d2;

  // Reference model: each requester is idle, or owns one op whose product is due at a known cycle.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int L = (g == 0) ? 0 : 2;
    logic [N_REQ-1:0] busy, eg, ev;
    logic [WP-1:0]    prd [N_REQ];
    logic [WA-1:0]    la;
    logic [WB-1:0]    lb;
    int               due [N_REQ];
    int               ptr, k, n_iss, n_drn;
    bit               found;

    always @(negedge clk) begin
      if (rst) begin
        busy  = '0;
        ptr   = 0;
        la    = '0;
        lb    = '0;
        n_iss = n_drn;
        chk($sformatf("rst_rsp_valid[lat%0d]", L), 32'(vld[g]), 32'd0);
        chk($sformatf("rst_mul_a[lat%0d]", L), 32'(ma[g]), 32'd0);
        chk($sformatf("rst_idle[lat%0d]", L), 32'(idl[g]), 32'd1);
      end else begin
        eg    = '0;
        found = 1'b0;
        k     = 0;
        for (int j = 0; j < N_REQ; j++) begin
          if (!found && req_valid[(ptr+j)%N_REQ] && !busy[(ptr+j)%N_REQ]) begin
            k     = (ptr + j) % N_REQ;
            eg[k] = 1'b1;
            found = 1'b1;
          end
        end
        for (int i = 0; i < N_REQ; i++) ev[i] = busy[i] && (cyc >= due[i]);
        chk($sformatf("grant[lat%0d]", L), 32'(rdy[g]), 32'(eg));
        chk($sformatf("rsp_valid[lat%0d]", L), 32'(vld[g]), 32'(ev));
        for (int i = 0; i < N_REQ; i++) begin
          if (ev[i]) chk($sformatf("rsp_p%0d[lat%0d]", i, L), 32'(rp[g][i*WP +: WP]), 32'(prd[i]));
        end
        chk($sformatf("mul_a[lat%0d]", L), 32'(ma[g]), 32'(la));
        chk($sformatf("mul_b[lat%0d]", L), 32'(mb[g]), 32'(lb));
        chk($sformatf("idle[lat%0d]", L), 32'(idl[g]), 32'(~|busy));
        for (int i = 0; i < N_REQ; i++) begin
          if (ev[i] && rsp_ready[i]) begin
            busy[i] = 1'b0;
            n_drn++;
          end
        end
        if (found) begin
          busy[k] = 1'b1;
          due[k]  = cyc + L + 2;
          la      = req_a[k*WA +: WA];
          lb      = req_b[k*WB +: WB];
          prd[k]  = prod(la, lb);
          ptr     = (k + 1) % N_REQ;
          n_iss++;
        end
      end
    end
  end

  int       lastg [2][N_REQ];
  int       others;
  bit       seen;
  logic [WP-1:0] pv;

  initial begin
    req_valid = '0;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst_lat0", 32'(idl[0]), 32'd1);
    chk("idle_after_rst_lat2", 32'(idl[1]), 32'd1);
    chk("ready_without_valid", 32'(rdy[0]), 32'd0);

    // single request, 25 x 3
    step(1);
    set_op(0, 11'd25, 10'd3);
    req_valid = N_REQ'(1);
    @(negedge clk);
    chk("single_ready", 32'(rdy[0]), 32'd1);
    step(1);
    req_valid = '0;
    @(negedge clk);
    chk("single_mul_a", 32'(ma[0]), 32'd25);
    chk("single_idle", 32'(idl[0]), 32'd0);
    step(1);
    @(negedge clk);
    chk("single_rsp_valid", 32'(vld[0][0]), 32'd1);
    chk("single_rsp_p", 32'(rp[0][WP-1:0]), 32'd75);

    // signed operands, -1 x 2
    step(4);
    set_op(1, 11'h7FF, 10'd2);
    req_valid = N_REQ'(2);
    @(negedge clk);
    chk("signed_ready", 32'(rdy[0]), 32'd2);
    step(1);
    req_valid = '0;
    step(1);
    @(negedge clk);
    chk("signed_rsp_valid_lat0", 32'(vld[0][1]), 32'd1);
    chk("signed_rsp_p_lat0", 32'(rp[0][WP +: WP]), 32'h1FFFFE);
    step(2);
    @(negedge clk);
    chk("signed_rsp_valid_lat2", 32'(vld[1][1]), 32'd1);
    chk("signed_rsp_p_lat2", 32'(rp[1][WP +: WP]), 32'h1FFFFE);

    // all requesters valid from the first cycle out of reset
    step(1);
    rst = 1'b1;
    step(2);
    rst       = 1'b0;
    req_valid = '1;
    rand_ops();
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < N_REQ; i++) lastg[g][i] = -1;
    for (int t = 0; t < 28; t++) begin
      @(negedge clk);
      if (t < N_REQ) begin
        chk($sformatf("order%0d_lat0", t), 32'(rdy[0]), 32'(1 << t));
        chk($sformatf("order%0d_lat2", t), 32'(rdy[1]), 32'(1 << t));
      end
      for (int g = 0; g < 2; g++) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (rdy[g][i]) begin
            if (lastg[g][i] >= 0)
              chk("regrant_gap", 32'((cyc - lastg[g][i]) >= ((g == 0) ? 3 : 5)), 32'd1);
            lastg[g][i] = cyc;
          end
        end
      end
      step(1);
      rand_ops();
    end

    // backpressure on requester 2
    rsp_ready[2] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step(1);
      rand_ops();
      @(negedge clk);
      if (vld[0][2]) seen = 1'b1;
    end
    chk("bp_wait_timeout", 32'(seen), 32'd1);
    pv     = rp[0][2*WP +: WP];
    others = 0;
    for (int t = 0; t < 10; t++) begin
      step(1);
      rand_ops();
      @(negedge clk);
      chk("bp_rsp_valid_hold", 32'(vld[0][2]), 32'd1);
      chk("bp_rsp_p_hold", 32'(rp[0][2*WP +: WP]), 32'(pv));
      chk("bp_no_grant2", 32'(rdy[0][2]), 32'd0);
      if (|(rdy[0] & ~N_REQ'(4))) others++;
    end
    chk("bp_others_served", 32'(others > 0), 32'd1);
    rsp_ready = '1;

    // reset one cycle after a LAT=2 handshake
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step(1);
      @(negedge clk);
      if (rdy[1] != '0) seen = 1'b1;
    end
    chk("midrst_wait_timeout", 32'(seen), 32'd1);
    step(1);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(vld[1]), 32'd0);
    chk("midrst_mul_a", 32'(ma[1]), 32'd0);
    chk("midrst_idle", 32'(idl[1]), 32'd1);
    step(2);
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk("midrst_no_late_rsp", 32'(vld[1]), 32'd0);
      step(1);
    end

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      step(1);
      req_valid = N_REQ'($urandom);
      rand_ops();
      for (int i = 0; i < N_REQ; i++) rsp_ready[i] = ($urandom_range(3) != 0);
    end

    step(1);
    req_valid = '0;
    rsp_ready = '1;
    step(10);
    @(negedge clk);
    chk("final_idle_lat0", 32'(idl[0]), 32'd1);
    chk("final_idle_lat2", 32'(idl[1]), 32'd1);
    chk("issued_vs_drained_lat0", 32'(mdl[0].n_drn), 32'(mdl[0].n_iss));
    chk("issued_vs_drained_lat2", 32'(mdl[1].n_drn), 32'(mdl[1].n_iss));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
